// File: rtl/state_taker.sv
// Frame parser: collects typed records 01..05 into shadow fields and commits them on a valid footer.
// Optional build macro STATE_TAKER_STRICT_PAD_EN rejects nonzero pad bits with error code 5.
module state_taker #(
  parameter int IDLE_TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   byte_in,
  input  logic         byte_valid,
  output logic [4:0]   password_len,
  output logic [159:0] password_chars,
  output logic [255:0] hashes_head,
  output logic [127:0] current_hash,
  output logic [4:0]   ntcrackfpga_state,
  output logic [3:0]   hashchecker_state,
  output logic [5:0]   md4block_step,
  output logic         frame_done,
  output logic         frame_error,
  output logic [2:0]   error_code
);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);

  typedef enum logic [2:0] {HUNT = 3'd0, HDR = 3'd1, TYPE = 3'd2, PAYLOAD = 3'd3, FTR = 3'd4} state_t;

  state_t          r_state;
  logic [1:0]      r_idx;
  logic [2:0]      r_exp;
  logic [5:0]      r_cnt;
  logic [IW-1:0]   r_idle;
  logic [4:0]      r_sh_len;
  logic [159:0]    r_sh_chars;
  logic [255:0]    r_sh_hashes;
  logic [127:0]    r_sh_hash;
  logic [4:0]      r_sh_nt;
  logic [3:0]      r_sh_hc;
  logic [5:0]      r_sh_md;
  logic [4:0]      r_len;
  logic [159:0]    r_chars;
  logic [255:0]    r_hashes;
  logic [127:0]    r_hash;
  logic [4:0]      r_nt;
  logic [3:0]      r_hc;
  logic [5:0]      r_md;
  logic            r_frame_done;
  logic            r_frame_error;
  logic [2:0]      r_error_code;
  logic            w_err;
  logic [2:0]      w_err_code;
  logic            w_pad_bad;

  function automatic logic [7:0] hdr_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    hdr_byte = 8'h0A;
      2'd1:    hdr_byte = 8'h55;
      2'd2:    hdr_byte = 8'hFA;
      default: hdr_byte = 8'hCE;
    endcase
  endfunction

  function automatic logic [7:0] ftr_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    ftr_byte = 8'hA2;
      2'd1:    ftr_byte = 8'h5E;
      2'd2:    ftr_byte = 8'hFA;
      default: ftr_byte = 8'hCE;
    endcase
  endfunction

  function automatic logic [5:0] pay_len(input logic [2:0] t);
    case (t)
      3'd1:    pay_len = 6'd1;
      3'd2:    pay_len = 6'd20;
      3'd3:    pay_len = 6'd32;
      3'd4:    pay_len = 6'd16;
      default: pay_len = 6'd3;
    endcase
  endfunction

`ifdef STATE_TAKER_STRICT_PAD_EN
  // Type 05 payload order is ntcrack (5b), hashchecker (4b), md4 step (6b); r_cnt counts down 3..1.
  function automatic logic pad_bad(input logic [2:0] t, input logic [5:0] cnt, input logic [7:0] b);
    case (t)
      3'd1: pad_bad = (b[7:5] != 3'd0);
      3'd5: begin
        case (cnt)
          6'd3:    pad_bad = (b[7:5] != 3'd0);
          6'd2:    pad_bad = (b[7:4] != 4'd0);
          default: pad_bad = (b[7:6] != 2'd0);
        endcase
      end
      default: pad_bad = 1'b0;
    endcase
  endfunction
  assign w_pad_bad = pad_bad(r_exp, r_cnt, byte_in);
`else
  assign w_pad_bad = 1'b0;
`endif

  // Error detection for the current edge: byte mismatches or idle timeout.
  always_comb begin
    w_err      = 1'b0;
    w_err_code = 3'd0;
    if (byte_valid) begin
      case (r_state)
        HDR:     begin w_err = (byte_in != hdr_byte(r_idx));   w_err_code = 3'd1; end
        TYPE:    begin w_err = (byte_in != {5'd0, r_exp});     w_err_code = 3'd2; end
        PAYLOAD: begin w_err = w_pad_bad;                      w_err_code = 3'd5; end
        FTR:     begin w_err = (byte_in != ftr_byte(r_idx));   w_err_code = 3'd3; end
        default: begin w_err = 1'b0;                           w_err_code = 3'd0; end
      endcase
    end else begin
      w_err      = (r_state != HUNT) && (r_idle == IDLE_LAST);
      w_err_code = 3'd4;
    end
  end

  // Parser FSM, shadow capture and atomic commit of the output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= HUNT;        r_idx <= 2'd0;          r_exp <= 3'd1;
      r_cnt <= 6'd0;          r_idle <= '0;
      r_sh_len <= 5'd0;       r_sh_chars <= 160'd0;   r_sh_hashes <= 256'd0;
      r_sh_hash <= 128'd0;    r_sh_nt <= 5'd0;        r_sh_hc <= 4'd0;   r_sh_md <= 6'd0;
      r_len <= 5'd0;          r_chars <= 160'd0;      r_hashes <= 256'd0;
      r_hash <= 128'd0;       r_nt <= 5'd0;           r_hc <= 4'd0;      r_md <= 6'd0;
      r_frame_done <= 1'b0;   r_frame_error <= 1'b0;  r_error_code <= 3'd0;
    end else begin
      r_frame_done  <= 1'b0;
      r_frame_error <= w_err;
      if (w_err) begin
        r_error_code <= w_err_code;
        r_idle       <= '0;
        if (byte_valid && byte_in == 8'h0A) begin
          r_state <= HDR;
          r_idx   <= 2'd1;
          r_exp   <= 3'd1;
        end else begin
          r_state <= HUNT;
        end
      end else begin
        r_idle <= (byte_valid || r_state == HUNT) ? '0 : r_idle + 1'b1;
        if (byte_valid) begin
          case (r_state)
            HUNT: begin
              if (byte_in == 8'h0A) begin
                r_state <= HDR;
                r_idx   <= 2'd1;
                r_exp   <= 3'd1;
              end
            end
            HDR: begin
              r_idx <= r_idx + 2'd1;
              if (r_idx == 2'd3) r_state <= TYPE;
            end
            TYPE: begin
              r_cnt   <= pay_len(r_exp);
              r_state <= PAYLOAD;
            end
            PAYLOAD: begin
              r_cnt <= r_cnt - 6'd1;
              case (r_exp)
                3'd1: r_sh_len    <= byte_in[4:0];
                3'd2: r_sh_chars  <= {r_sh_chars[151:0], byte_in};
                3'd3: r_sh_hashes <= {r_sh_hashes[247:0], byte_in};
                3'd4: r_sh_hash   <= {r_sh_hash[119:0], byte_in};
                default: begin
                  case (r_cnt)
                    6'd3:    r_sh_nt <= byte_in[4:0];
                    6'd2:    r_sh_hc <= byte_in[3:0];
                    default: r_sh_md <= byte_in[5:0];
                  endcase
                end
              endcase
              if (r_cnt == 6'd1) begin
                r_idx <= 2'd0;
                if (r_exp == 3'd5) begin
                  r_state <= FTR;
                end else begin
                  r_exp   <= r_exp + 3'd1;
                  r_state <= HDR;
                end
              end
            end
            FTR: begin
              r_idx <= r_idx + 2'd1;
              if (r_idx == 2'd3) begin
                r_len <= r_sh_len;   r_chars <= r_sh_chars;   r_hashes <= r_sh_hashes;
                r_hash <= r_sh_hash; r_nt <= r_sh_nt;         r_hc <= r_sh_hc;   r_md <= r_sh_md;
                r_frame_done <= 1'b1;
                r_state      <= HUNT;
              end
            end
            default: r_state <= HUNT;
          endcase
        end
      end
    end
  end

  assign password_len      = r_len;
  assign password_chars    = r_chars;
  assign hashes_head       = r_hashes;
  assign current_hash      = r_hash;
  assign ntcrackfpga_state = r_nt;
  assign hashchecker_state = r_hc;
  assign md4block_step     = r_md;
  assign frame_done        = r_frame_done;
  assign frame_error       = r_frame_error;
  assign error_code        = r_error_code;
endmodule
